// File: rtl/snac_joybus_seq.sv
// snac_joybus_seq
// Sequences one joybus transaction through the SNAC PHY: sends req_txcnt
// command bytes from the tx buffer using the PHY's start / toPad_ena
// handshake, collects up to req_rxcnt reply bytes into the rx buffer, then
// pulses done with a status code.
//
// Ports
//   clk_1x, reset                 PHY clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready == idle)
//   req_txcnt/req_rxcnt           bytes to send / bytes expected back
//   wr_en/wr_addr/wr_data         tx buffer write port (only while idle)
//   rd_addr/rd_data               rx buffer read port, 1-cycle latency
//   done/status/rx_len            completion pulse, result code, bytes received
//   snac_start/snac_toPad_ena     one-cycle pulses to the PHY
//   snac_cmd_data                 byte currently presented to the PHY
//   snac_send_cnt/receive_cnt     latched request counts
//   snac_ready/byte_rec/timeout   PHY status
//   snac_data_out                 PHY received byte
module snac_joybus_seq #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_1x,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_txcnt,
    input  logic [AW-1:0] req_rxcnt,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          done,
    output logic [1:0]    status,
    output logic [AW-1:0] rx_len,
    output logic          snac_start,
    output logic          snac_toPad_ena,
    output logic [7:0]    snac_cmd_data,
    output logic [AW-1:0] snac_send_cnt,
    output logic [AW-1:0] snac_receive_cnt,
    input  logic          snac_ready,
    input  logic          snac_byte_rec,
    input  logic          snac_timeout,
    input  logic [7:0]    snac_data_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_GUARD, S_TXWAIT, S_NEXT, S_RXWAIT, S_DONE
    } state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_BADLEN  = 2'd2;

    state_t        r_state;
    logic          r_req_ready;
    logic          r_done;
    logic [1:0]    r_status;
    logic [AW-1:0] r_rx_len;
    logic          r_start;
    logic          r_topad;
    logic [7:0]    r_cmd;
    logic [AW-1:0] r_tx_cnt;
    logic [AW-1:0] r_rx_cnt;
    logic [AW-1:0] r_tx_idx;
    logic [AW-1:0] r_rx_idx;
    logic          r_gcnt;
    logic [7:0]    r_rd_data;

    logic [7:0]    r_tx_mem [DEPTH];
    logic [7:0]    r_rx_mem [DEPTH];

    logic          w_tx_we;
    logic          w_rx_we;
    logic [AW-1:0] w_rx_idx_nx;
    logic          w_rx_full;

    // Host may only load the tx buffer while nothing is in flight.
    assign w_tx_we     = wr_en & r_req_ready;
    // Bytes beyond the expected count are dropped rather than wrapping.
    assign w_rx_we     = (r_state == S_RXWAIT) & snac_byte_rec & (r_rx_idx != r_rx_cnt);
    assign w_rx_idx_nx = r_rx_idx + AW'(w_rx_we);
    assign w_rx_full   = w_rx_we & (w_rx_idx_nx == r_rx_cnt);

    always_ff @(posedge clk_1x) begin
        if (w_tx_we) r_tx_mem[wr_addr] <= wr_data;
        if (w_rx_we) r_rx_mem[r_rx_idx] <= snac_data_out;
    end

    always_ff @(posedge clk_1x) begin
        if (reset) r_rd_data <= '0;
        else       r_rd_data <= r_rx_mem[rd_addr];
    end

    always_ff @(posedge clk_1x) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_done      <= 1'b0;
            r_status    <= ST_OK;
            r_rx_len    <= '0;
            r_start     <= 1'b0;
            r_topad     <= 1'b0;
            r_cmd       <= '0;
            r_tx_cnt    <= '0;
            r_rx_cnt    <= '0;
            r_tx_idx    <= '0;
            r_rx_idx    <= '0;
            r_gcnt      <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_topad <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_tx_cnt    <= req_txcnt;
                        r_rx_cnt    <= req_rxcnt;
                        r_rx_idx    <= '0;
                        r_req_ready <= 1'b0;
                        if (req_txcnt == '0) begin
                            r_status <= ST_BADLEN;
                            r_rx_len <= '0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_cmd    <= r_tx_mem[0];
                            r_tx_idx <= AW'(1);
                            r_state  <= S_START;
                        end
                    end
                end
                S_START: begin
                    if (snac_ready) begin
                        r_start <= 1'b1;
                        r_gcnt  <= 1'b0;
                        r_state <= S_GUARD;
                    end
                end
                // The PHY still shows ready for a cycle after each pulse;
                // sit out two cycles so that stale ready is not taken as a
                // byte boundary.
                S_GUARD: begin
                    if (r_gcnt) r_state <= (r_tx_idx == r_tx_cnt) ? S_RXWAIT : S_TXWAIT;
                    else        r_gcnt  <= 1'b1;
                end
                S_TXWAIT: begin
                    if (snac_ready) begin
                        r_cmd    <= r_tx_mem[r_tx_idx];
                        r_tx_idx <= r_tx_idx + AW'(1);
                        r_state  <= S_NEXT;
                    end
                end
                // cmd_data was updated last cycle, so it is stable under toPad_ena.
                S_NEXT: begin
                    r_topad <= 1'b1;
                    r_gcnt  <= 1'b0;
                    r_state <= S_GUARD;
                end
                // A byte arriving with the timeout is stored first, so the
                // status reflects the final count.
                S_RXWAIT: begin
                    r_rx_idx <= w_rx_idx_nx;
                    if (w_rx_full || snac_timeout) begin
                        r_done   <= 1'b1;
                        r_rx_len <= w_rx_idx_nx;
                        r_status <= (w_rx_idx_nx == r_rx_cnt) ? ST_OK : ST_TIMEOUT;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready        = r_req_ready;
    assign done             = r_done;
    assign status           = r_status;
    assign rx_len           = r_rx_len;
    assign snac_start       = r_start;
    assign snac_toPad_ena   = r_topad;
    assign snac_cmd_data    = r_cmd;
    assign snac_send_cnt    = r_tx_cnt;
    assign snac_receive_cnt = r_rx_cnt;
    assign rd_data          = r_rd_data;

endmodule
